// File: rtl/lsu_dcache_if.sv
// Load/store unit between the RV32I execute stage and a word-wide d_cache.
// One request at a time; sub-word stores are done as read-modify-write.
module lsu_dcache_if #(
    parameter int unsigned DPW   = 32,
    parameter int unsigned Depth = 120
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [2:0]     req_funct3,
    input  logic [DPW-1:0] req_addr,
    input  logic [DPW-1:0] req_wdata,
    output logic           rsp_valid,
    output logic [DPW-1:0] rsp_rdata,
    output logic [1:0]     rsp_err,
    output logic [DPW-1:0] dc_addr,
    output logic [DPW-1:0] dc_wd,
    output logic [DPW-1:0] dc_we,
    input  logic [DPW-1:0] dc_rd
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_t;

    localparam logic [1:0] ErrOk       = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrRange    = 2'b10;
    localparam logic [1:0] ErrFunct3   = 2'b11;

    state_t           state_q, state_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [DPW-1:0]   addr_q;
    logic [DPW-1:0]   word_q;
    logic [DPW-1:0]   rdata_q;
    logic [1:0]       err_q;

    logic             f3_illegal;
    logic             misaligned;
    logic             out_of_range;
    logic [2:0]       size_m1;
    logic [DPW:0]     last_byte;
    logic [1:0]       req_err;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [DPW-1:0]   load_val;
    logic [DPW-1:0]   merged;

    // Request checks, evaluated on the accept cycle only.
    always_comb begin
        f3_illegal = 1'b0;
        size_m1    = 3'd0;
        unique case (req_funct3)
            3'b000: size_m1 = 3'd0;
            3'b001: size_m1 = 3'd1;
            3'b010: size_m1 = 3'd3;
            3'b100: begin
                size_m1    = 3'd0;
                f3_illegal = req_we;
            end
            3'b101: begin
                size_m1    = 3'd1;
                f3_illegal = req_we;
            end
            default: f3_illegal = 1'b1;
        endcase
    end

    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

    // One extra bit so an address near the top cannot wrap back into range.
    assign last_byte    = {1'b0, req_addr} + (DPW+1)'(size_m1);
    assign out_of_range = last_byte >= (DPW+1)'(Depth);

    always_comb begin
        req_err = ErrOk;
        if (f3_illegal) begin
            req_err = ErrFunct3;
        end else if (misaligned) begin
            req_err = ErrMisalign;
        end else if (out_of_range) begin
            req_err = ErrRange;
        end
    end

    // Lane extraction and merge use the latched address against live dc_rd.
    assign ld_byte = dc_rd[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = dc_rd[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = dc_rd;
        unique case (funct3_q)
            3'b000:  load_val = {{(DPW-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {{(DPW-8){1'b0}}, ld_byte};
            3'b001:  load_val = {{(DPW-16){ld_half[15]}}, ld_half};
            3'b101:  load_val = {{(DPW-16){1'b0}}, ld_half};
            default: load_val = dc_rd;
        endcase
    end

    always_comb begin
        merged = dc_rd;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
        end else if (funct3_q[1:0] == 2'b01) begin
            merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err != ErrOk) begin
                        state_d = StResp;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = we_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= ErrOk;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        word_q   <= req_wdata;
                        if (req_err != ErrOk) begin
                            rdata_q <= '0;
                            err_q   <= req_err;
                        end
                    end
                end
                StRd: begin
                    if (we_q) begin
                        word_q <= merged;
                    end else begin
                        rdata_q <= load_val;
                        err_q   <= ErrOk;
                    end
                end
                StWr: begin
                    rdata_q <= '0;
                    err_q   <= ErrOk;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dc_addr   = ((state_q == StRd) || (state_q == StWr)) ? {addr_q[DPW-1:2], 2'b00} : '0;
    assign dc_wd     = (state_q == StWr) ? word_q : '0;
    assign dc_we     = (state_q == StWr) ? {{(DPW-1){1'b0}}, 1'b1} : '0;

endmodule

// File: tb/tb_lsu_dcache_if.sv
// Scoreboard bench for lsu_dcache_if: directed requests against a small d_cache model.
module tb_lsu_dcache_if;

    logic        clk;
    logic        arst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] dc_addr;
    logic [31:0] dc_wd;
    logic [31:0] dc_we;
    logic [31:0] dc_rd;

    logic [31:0] mem [0:29];
    logic        pl_en;
    logic [4:0]  pl_idx;
    logic [31:0] pl_val;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          wr;
    } exp_t;

    exp_t sb_q[$];
    int   acc_log[$];
    int   rsp_log[$];
    int   checks;
    int   errors;

    lsu_dcache_if #(.DPW(32), .Depth(120)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dc_addr    (dc_addr),
        .dc_wd      (dc_wd),
        .dc_we      (dc_we),
        .dc_rd      (dc_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dc_rd = (dc_addr[31:2] < 30) ? mem[dc_addr[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if ((dc_we == 32'h1) && (dc_addr[31:2] < 30)) begin
            mem[dc_addr[6:2]] <= dc_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: tracks accepts and writes, pops the scoreboard on each response.
    initial begin
        int   n;
        int   acc_n;
        int   wr_cnt;
        logic prev_rsp;
        logic [31:0] prev_rdata;
        logic [1:0]  prev_err;
        exp_t e;
        n = 0;
        acc_n = 0;
        wr_cnt = 0;
        prev_rsp = 1'b0;
        prev_rdata = '0;
        prev_err = '0;
        forever begin
            @(negedge clk);
            n++;
            if (prev_rsp && arst_n) begin
                check("rsp_valid_drop", {31'b0, rsp_valid}, 32'h0);
                check("rsp_rdata_hold", rsp_rdata, prev_rdata);
                check("rsp_err_hold", {30'b0, rsp_err}, {30'b0, prev_err});
            end
            prev_rsp = 1'b0;
            if (dc_we != 32'h0) begin
                wr_cnt++;
                check("dc_we_value", dc_we, 32'h1);
            end
            if (rsp_valid) begin
                rsp_log.push_back(n);
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {30'b0, rsp_err}, {30'b0, e.err});
                    check("latency", 32'(n - acc_n), 32'(e.lat));
                    check("dc_writes", 32'(wr_cnt), 32'(e.wr));
                end
                prev_rsp   = 1'b1;
                prev_rdata = rsp_rdata;
                prev_err   = rsp_err;
            end
            if (req_valid && req_ready && arst_n) begin
                acc_n  = n;
                wr_cnt = 0;
                acc_log.push_back(n);
            end
        end
    end

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic [1:0] ee,
                         input int lat, input int wr);
        bit ok;
        sb_q.push_back('{er, ee, lat, wr});
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        checks     = 0;
        errors     = 0;
        arst_n     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        pl_en      = 1'b0;
        pl_idx     = '0;
        pl_val     = '0;

        for (int i = 0; i < 30; i++) preload(5'(i), 32'h0);
        preload(5'd0, 32'h8081_7F05);
        preload(5'd1, 32'h1122_3344);
        preload(5'd3, 32'h5555_5555);
        preload(5'd29, 32'hCAFE_F00D);

        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {30'b0, rsp_err}, 32'h0);
        check("rst_dc_addr", dc_addr, 32'h0);
        check("rst_dc_wd", dc_wd, 32'h0);
        check("rst_dc_we", dc_we, 32'h0);

        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Loads on word0 = 0x8081_7F05.
        issue(1'b0, 3'b000, 32'd0, 32'h0, 32'h0000_0005, 2'b00, 2, 0);
        issue(1'b0, 3'b000, 32'd2, 32'h0, 32'hFFFF_FF81, 2'b00, 2, 0);
        issue(1'b0, 3'b100, 32'd3, 32'h0, 32'h0000_0080, 2'b00, 2, 0);
        issue(1'b0, 3'b001, 32'd2, 32'h0, 32'hFFFF_8081, 2'b00, 2, 0);
        issue(1'b0, 3'b101, 32'd2, 32'h0, 32'h0000_8081, 2'b00, 2, 0);
        issue(1'b0, 3'b010, 32'd0, 32'h0, 32'h8081_7F05, 2'b00, 2, 0);

        // Sub-word stores on word1 = 0x1122_3344.
        issue(1'b1, 3'b000, 32'd7, 32'h0000_000A, 32'h0, 2'b00, 3, 1);
        issue(1'b0, 3'b010, 32'd4, 32'h0, 32'h0A22_3344, 2'b00, 2, 0);
        issue(1'b1, 3'b001, 32'd4, 32'h1234_BEEF, 32'h0, 2'b00, 3, 1);
        issue(1'b0, 3'b010, 32'd4, 32'h0, 32'h0A22_BEEF, 2'b00, 2, 0);

        // Errors and range edges.
        issue(1'b0, 3'b010, 32'd2, 32'h0, 32'h0, 2'b01, 1, 0);
        issue(1'b1, 3'b001, 32'd1, 32'hFFFF, 32'h0, 2'b01, 1, 0);
        issue(1'b0, 3'b010, 32'd120, 32'h0, 32'h0, 2'b10, 1, 0);
        issue(1'b0, 3'b000, 32'd119, 32'h0, 32'hFFFF_FFCA, 2'b00, 2, 0);
        issue(1'b0, 3'b001, 32'd118, 32'h0, 32'hFFFF_CAFE, 2'b00, 2, 0);
        issue(1'b0, 3'b001, 32'd119, 32'h0, 32'h0, 2'b01, 1, 0);
        issue(1'b0, 3'b011, 32'd0, 32'h0, 32'h0, 2'b11, 1, 0);
        issue(1'b0, 3'b110, 32'd0, 32'h0, 32'h0, 2'b11, 1, 0);
        issue(1'b1, 3'b100, 32'd0, 32'hFF, 32'h0, 2'b11, 1, 0);
        issue(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'b10, 1, 0);
        issue(1'b1, 3'b010, 32'd116, 32'h1234_5678, 32'h0, 2'b00, 2, 1);
        issue(1'b0, 3'b010, 32'd116, 32'h0, 32'h1234_5678, 2'b00, 2, 0);

        // Back-to-back: LW held on req_valid right behind SW.
        drain();
        @(posedge clk);
        #1;
        k = acc_log.size();
        issue(1'b1, 3'b010, 32'd8, 32'hDEAD_BEEF, 32'h0, 2'b00, 2, 1);
        issue(1'b0, 3'b010, 32'd8, 32'h0, 32'hDEAD_BEEF, 2'b00, 2, 0);
        drain();
        if (acc_log.size() > k + 1 && rsp_log.size() > k) begin
            check("b2b_accept", 32'(acc_log[k+1]), 32'(rsp_log[k] + 1));
        end else begin
            check("b2b_logs", 32'(rsp_log.size()), 32'(k + 1));
        end
        check("mem_word1", mem[1], 32'h0A22_BEEF);
        check("mem_word2", mem[2], 32'hDEAD_BEEF);

        // Reset landing during the RD of an SB.
        @(posedge clk);
        #1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'd13;
        req_wdata  = 32'h0000_00AA;
        req_valid  = 1'b1;
        @(negedge clk);
        check("rst_test_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rd_dc_addr", dc_addr, 32'd12);
        check("rd_dc_we", dc_we, 32'h0);
        arst_n = 1'b0;
        #1;
        check("mid_rst_dc_we", dc_we, 32'h0);
        check("mid_rst_dc_addr", dc_addr, 32'h0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'h1);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mem_word3_kept", mem[3], 32'h5555_5555);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);
        check("post_rst_dc_we", dc_we, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("mem_word3_final", mem[3], 32'h5555_5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
